// File: rtl/accelerator_types.sv
// Shared types for the accelerator control path: responder FSM states and
// MIG native-interface command encodings.
package accelerator_types;

  typedef enum logic [1:0] {
    S_R_IDLE,
    S_R_RD,
    S_R_WR,
    S_R_BRESP
  } mig_resp_state_e;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

endpackage : accelerator_types

// File: rtl/accel_mig_responder.sv
// Responder end of the accelerator-to-DRAM request channel. Turns burst
// read/write requests into per-beat MIG app commands and returns read beats
// in issue order. Single clock domain (MIG UI clock).
module accel_mig_responder
  import accelerator_types::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 1024,
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_ADDR_SHIFT = 3,
  parameter int APP_ADDR_INC   = (DATA_WIDTH / 8) >> APP_ADDR_SHIFT
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  // request channel
  input  logic [ADDR_WIDTH-1:0]       addr_i,
  input  logic                        arvalid_i,
  output logic                        arready_o,
  input  logic                        awvalid_i,
  output logic                        awready_o,
  input  logic [7:0]                  arwlen_i,
  // read return
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        data_valid_o,
  output logic                        rw_last_o,
  // write beats
  input  logic [DATA_WIDTH-1:0]       wdata_i,
  input  logic [DATA_WIDTH/8-1:0]     wstrb_i,
  input  logic                        wvalid_i,
  input  logic                        wlast_i,
  output logic                        wready_o,
  // write response
  output logic                        bvalid_o,
  input  logic                        bready_i,
  output logic                        wlast_err_o,
  // MIG app command
  output logic [APP_ADDR_WIDTH-1:0]   app_addr_o,
  output logic [2:0]                  app_cmd_o,
  output logic                        app_en_o,
  input  logic                        app_rdy_i,
  // MIG app write data
  output logic [DATA_WIDTH-1:0]       app_wdf_data_o,
  output logic [DATA_WIDTH/8-1:0]     app_wdf_mask_o,
  output logic                        app_wdf_wren_o,
  output logic                        app_wdf_end_o,
  input  logic                        app_wdf_rdy_i,
  // MIG app read data
  input  logic [DATA_WIDTH-1:0]       app_rd_data_i,
  input  logic                        app_rd_data_valid_i,
  input  logic                        app_rd_data_end_i
);

  localparam logic [APP_ADDR_WIDTH-1:0] ADDR_STEP = APP_ADDR_WIDTH'(APP_ADDR_INC);

  mig_resp_state_e            state_q, state_d;
  logic [APP_ADDR_WIDTH-1:0]  app_addr_q;
  logic [8:0]                 beats_q;     // burst length, 1..256
  logic [8:0]                 issued_q;    // commands accepted by MIG
  logic [8:0]                 returned_q;  // read beats handed back
  logic                       wr_fire;     // write beat + command accepted this cycle

  // One-beat-per-command MIG usage: every beat ends its own data burst.
  logic unused_rd_data_end;
  assign unused_rd_data_end = app_rd_data_end_i;

  // Write data passes straight through; MIG mask is active-high "skip byte".
  assign app_wdf_data_o = wdata_i;
  assign app_wdf_mask_o = ~wstrb_i;
  assign app_addr_o     = app_addr_q;

  // FSM state register
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of block evaluation order.
    if (reset_i) state_q <= S_R_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic and combinational handshake/command outputs
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    arready_o      = 1'b0;
    awready_o      = 1'b0;
    wready_o       = 1'b0;
    wr_fire        = 1'b0;
    app_en_o       = 1'b0;
    app_cmd_o      = APP_CMD_WR;
    app_wdf_wren_o = 1'b0;
    app_wdf_end_o  = 1'b0;

    case (state_q)
      S_R_IDLE: begin
        arready_o = 1'b1;
        awready_o = ~arvalid_i;          // read wins a simultaneous request
        if (arvalid_i)      state_d = S_R_RD;
        else if (awvalid_i) state_d = S_R_WR;
      end

      S_R_RD: begin
        app_cmd_o = APP_CMD_RD;
        app_en_o  = (issued_q != beats_q);
        if (app_rd_data_valid_i && (returned_q == beats_q - 9'd1))
          state_d = S_R_IDLE;
      end

      S_R_WR: begin
        // Command and data are pushed together, so both MIG readies gate it.
        wready_o       = app_rdy_i & app_wdf_rdy_i & (issued_q != beats_q);
        wr_fire        = wvalid_i & wready_o;
        app_en_o       = wr_fire;
        app_wdf_wren_o = wr_fire;
        app_wdf_end_o  = wr_fire;
        if (wr_fire && (issued_q == beats_q - 9'd1))
          state_d = S_R_BRESP;
      end

      S_R_BRESP: begin
        if (bready_i) state_d = S_R_IDLE;
      end

      default: state_d = S_R_IDLE;
    endcase
  end

  // Burst bookkeeping, read return register, write response and error flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      app_addr_q   <= '0;
      beats_q      <= '0;
      issued_q     <= '0;
      returned_q   <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      rw_last_o    <= 1'b0;
      bvalid_o     <= 1'b0;
      wlast_err_o  <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      rw_last_o    <= 1'b0;

      case (state_q)
        S_R_IDLE: begin
          if (arvalid_i || awvalid_i) begin
            app_addr_q <= APP_ADDR_WIDTH'(addr_i >> APP_ADDR_SHIFT);
            beats_q    <= {1'b0, arwlen_i} + 9'd1;
            issued_q   <= '0;
            returned_q <= '0;
          end
        end

        S_R_RD: begin
          if (app_en_o && app_rdy_i) begin
            issued_q   <= issued_q + 9'd1;
            app_addr_q <= app_addr_q + ADDR_STEP;
          end
          // MIG returns reads in issue order; no backpressure downstream.
          if (app_rd_data_valid_i) begin
            data_o       <= app_rd_data_i;
            data_valid_o <= 1'b1;
            returned_q   <= returned_q + 9'd1;
            rw_last_o    <= (returned_q == beats_q - 9'd1);
          end
        end

        S_R_WR: begin
          if (wr_fire) begin
            issued_q   <= issued_q + 9'd1;
            app_addr_q <= app_addr_q + ADDR_STEP;
            // Beat counter is authoritative; a misplaced wlast only flags.
            if (wlast_i != (issued_q == beats_q - 9'd1))
              wlast_err_o <= 1'b1;
            if (issued_q == beats_q - 9'd1)
              bvalid_o <= 1'b1;
          end
        end

        S_R_BRESP: begin
          if (bready_i) bvalid_o <= 1'b0;
        end

        default: ;
      endcase
    end
  end

endmodule : accel_mig_responder

// File: tb/tb_accel_mig_responder.sv
// Directed self-checking bench for accel_mig_responder.
module tb_accel_mig_responder;

  localparam int DW  = 1024;
  localparam int AAW = 28;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [31:0]     addr_i;
  logic            arvalid_i, arready_o, awvalid_i, awready_o;
  logic [7:0]      arwlen_i;
  logic [DW-1:0]   data_o;
  logic            data_valid_o, rw_last_o;
  logic [DW-1:0]   wdata_i;
  logic [DW/8-1:0] wstrb_i;
  logic            wvalid_i, wlast_i, wready_o;
  logic            bvalid_o, bready_i, wlast_err_o;
  logic [AAW-1:0]  app_addr_o;
  logic [2:0]      app_cmd_o;
  logic            app_en_o, app_rdy_i;
  logic [DW-1:0]   app_wdf_data_o;
  logic [DW/8-1:0] app_wdf_mask_o;
  logic            app_wdf_wren_o, app_wdf_end_o, app_wdf_rdy_i;
  logic [DW-1:0]   app_rd_data_i;
  logic            app_rd_data_valid_i, app_rd_data_end_i;

  accel_mig_responder dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .addr_i(addr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .awvalid_i(awvalid_i), .awready_o(awready_o), .arwlen_i(arwlen_i),
    .data_o(data_o), .data_valid_o(data_valid_o), .rw_last_o(rw_last_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wlast_i(wlast_i),
    .wready_o(wready_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .wlast_err_o(wlast_err_o),
    .app_addr_o(app_addr_o), .app_cmd_o(app_cmd_o), .app_en_o(app_en_o),
    .app_rdy_i(app_rdy_i),
    .app_wdf_data_o(app_wdf_data_o), .app_wdf_mask_o(app_wdf_mask_o),
    .app_wdf_wren_o(app_wdf_wren_o), .app_wdf_end_o(app_wdf_end_o),
    .app_wdf_rdy_i(app_wdf_rdy_i),
    .app_rd_data_i(app_rd_data_i), .app_rd_data_valid_i(app_rd_data_valid_i),
    .app_rd_data_end_i(app_rd_data_end_i)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Read-beat payload pattern and the low 128 bits the bench expects back.
  function automatic logic [DW-1:0] beat_pat(input int k);
    return {32{32'hC0DE_0000 + 32'(k)}};
  endfunction

  function automatic logic [127:0] exp128(input int k);
    return {4{32'hC0DE_0000 + 32'(k)}};
  endfunction

  // Passive monitor: logs accepted commands, write beats and read returns.
  logic [AAW-1:0] cmd_addr_q[$];
  logic [2:0]     cmd_op_q[$];
  logic [127:0]   wd_q[$];
  logic [127:0]   rd_q[$];
  logic           last_q[$];
  int             wren_cnt = 0;
  int             wr_bad   = 0;
  logic           ar_at_last = 1'b0;
  logic           aw_at_last = 1'b0;

  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (app_en_o && app_rdy_i) begin
        cmd_addr_q.push_back(app_addr_o);
        cmd_op_q.push_back(app_cmd_o);
      end
      if (app_wdf_wren_o) begin
        wren_cnt++;
        wd_q.push_back(app_wdf_data_o[127:0]);
        if (app_wdf_mask_o != '0 || !app_wdf_end_o || !app_en_o) wr_bad++;
      end
      if (data_valid_o) begin
        rd_q.push_back(data_o[127:0]);
        last_q.push_back(rw_last_o);
        if (rw_last_o) begin
          ar_at_last = arready_o;
          aw_at_last = awready_o;
        end
      end
    end
  end

  // Present a read request and wait until all its commands have issued.
  task automatic issue_read(input logic [31:0] raddr, input int len, input bit with_aw,
                            input logic [31:0] next_addr, input bit stall);
    int c0 = cmd_addr_q.size();
    int n = 0;
    bit stalled = 1'b0;
    int hold_bad = 0;
    logic [AAW-1:0] exp_hold;
    @(posedge clk_i); #1;
    addr_i = raddr; arwlen_i = 8'(len); arvalid_i = 1'b1; awvalid_i = with_aw;
    @(negedge clk_i);
    check("ar_ready_idle", 128'(arready_o), 128'd1);
    check("aw_blocked_by_ar", 128'(awready_o), 128'd0);
    @(posedge clk_i); #1;
    arvalid_i = 1'b0; addr_i = next_addr;
    while (cmd_addr_q.size() - c0 < len + 1 && n < 400) begin
      @(posedge clk_i); #1;
      if (stall && !stalled && cmd_addr_q.size() - c0 == 2) begin
        stalled  = 1'b1;
        app_rdy_i = 1'b0;
        exp_hold = AAW'(raddr >> 3) + AAW'(32);
        repeat (20) begin
          @(negedge clk_i);
          if (!(app_en_o && app_addr_o == exp_hold)) hold_bad++;
        end
        check("stall_en_addr_held", 128'(hold_bad), 128'd0);
        @(posedge clk_i); #1;
        app_rdy_i = 1'b1;
      end
      @(negedge clk_i);
      n++;
    end
    check("rd_issue_in_time", 128'(n < 400), 128'd1);
  endtask

  // MIG returns nb beats after a 10-cycle latency.
  task automatic return_beats(input int nb, input int tag);
    repeat (10) @(posedge clk_i);
    #1;
    for (int k = 0; k < nb; k++) begin
      app_rd_data_i = beat_pat(tag + k);
      app_rd_data_valid_i = 1'b1;
      @(posedge clk_i); #1;
    end
    app_rd_data_valid_i = 1'b0;
    @(negedge clk_i); #1;
  endtask

  // Write burst; wlast is driven on wlast_beat. pending: awvalid already up.
  task automatic write_burst(input logic [31:0] waddr, input int len, input int wlast_beat,
                             input bit toggle, input bit pending);
    int beat = 0;
    int n = 0;
    if (!pending) begin
      @(posedge clk_i); #1;
      addr_i = waddr; arwlen_i = 8'(len); awvalid_i = 1'b1;
      @(negedge clk_i);
    end
    while (!awready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("aw_accepted", 128'(awready_o), 128'd1);
    @(posedge clk_i); #1;
    awvalid_i = 1'b0;
    n = 0;
    while (beat <= len && n < 300) begin
      wvalid_i      = 1'b1;
      wlast_i       = (beat == wlast_beat);
      wdata_i       = beat_pat(100 + beat);
      wstrb_i       = '1;
      app_wdf_rdy_i = toggle ? n[0] : 1'b1;
      @(negedge clk_i);
      if (wready_o) beat++;
      @(posedge clk_i); #1;
      n++;
    end
    wvalid_i = 1'b0; wlast_i = 1'b0; app_wdf_rdy_i = 1'b1;
    check("wr_beats_done", 128'(beat), 128'(len + 1));
  endtask

  // B channel: bvalid must be up now and stay up for hold cycles until bready.
  task automatic bresp(input int hold);
    @(negedge clk_i);
    check("bvalid_rise", 128'(bvalid_o), 128'd1);
    repeat (hold) @(posedge clk_i);
    @(negedge clk_i);
    check("bvalid_held", 128'(bvalid_o), 128'd1);
    @(posedge clk_i); #1;
    bready_i = 1'b1;
    @(posedge clk_i); #1;
    bready_i = 1'b0;
    @(negedge clk_i);
    check("bvalid_cleared", 128'(bvalid_o), 128'd0);
    check("idle_after_b", 128'(arready_o), 128'd1);
  endtask

  initial begin
    int c0, r0, w0, d0;
    logic [3:0] lastv;
    reset_i = 1'b1; addr_i = '0; arvalid_i = 1'b0; awvalid_i = 1'b0; arwlen_i = '0;
    wdata_i = '0; wstrb_i = '0; wvalid_i = 1'b0; wlast_i = 1'b0; bready_i = 1'b0;
    app_rdy_i = 1'b1; app_wdf_rdy_i = 1'b1; app_rd_data_i = '0;
    app_rd_data_valid_i = 1'b0; app_rd_data_end_i = 1'b0;

    // ---- reset values ----
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_arready", 128'(arready_o), 128'd1);
    check("rst_awready", 128'(awready_o), 128'd1);
    check("rst_data_valid", 128'(data_valid_o), 128'd0);
    check("rst_rw_last", 128'(rw_last_o), 128'd0);
    check("rst_bvalid", 128'(bvalid_o), 128'd0);
    check("rst_wlast_err", 128'(wlast_err_o), 128'd0);
    check("rst_app_en", 128'(app_en_o), 128'd0);
    check("rst_wren_end", 128'({app_wdf_wren_o, app_wdf_end_o}), 128'd0);
    check("rst_data", data_o[127:0], 128'd0);
    arvalid_i = 1'b1;
    #1 check("rst_awready_vs_arvalid", 128'(awready_o), 128'd0);
    arvalid_i = 1'b0;
    @(posedge clk_i); #1;
    reset_i = 1'b0;

    // ---- T1: 4-beat read at 0x1000 ----
    c0 = cmd_addr_q.size(); r0 = rd_q.size();
    issue_read(32'h1000, 3, 1'b0, 32'h0, 1'b0);
    return_beats(4, 0);
    for (int i = 0; i < 4; i++)
      check($sformatf("t1_cmd_addr%0d", i), 128'(cmd_addr_q[c0 + i]), 128'(28'h200 + 28'(16 * i)));
    check("t1_cmd_ops", 128'({cmd_op_q[c0], cmd_op_q[c0+1], cmd_op_q[c0+2], cmd_op_q[c0+3]}), 128'h249);
    check("t1_beats", 128'(rd_q.size() - r0), 128'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_data%0d", k), rd_q[r0 + k], exp128(k));
      lastv[k] = last_q[r0 + k];
    end
    check("t1_last_on_4th", 128'(lastv), 128'h8);
    check("t1_arready_after", 128'(ar_at_last), 128'd1);

    // ---- T2: 8-beat write, app_wdf_rdy toggling ----
    c0 = cmd_addr_q.size(); w0 = wren_cnt; d0 = wd_q.size();
    write_burst(32'h2000, 7, 7, 1'b1, 1'b0);
    check("t2_wren_count", 128'(wren_cnt - w0), 128'd8);
    check("t2_mask_end_en", 128'(wr_bad), 128'd0);
    check("t2_cmd_first", 128'(cmd_addr_q[c0]), 128'h400);
    check("t2_cmd_last", 128'(cmd_addr_q[c0 + 7]), 128'h470);
    check("t2_cmd_op", 128'(cmd_op_q[c0 + 3]), 128'd0);
    check("t2_wdata5", wd_q[d0 + 5], exp128(105));
    bresp(4);
    check("t2_wlast_err", 128'(wlast_err_o), 128'd0);

    // ---- T3: simultaneous read and write; read first ----
    c0 = cmd_addr_q.size(); w0 = wren_cnt;
    issue_read(32'h5000, 3, 1'b1, 32'h6000, 1'b0);
    return_beats(4, 20);
    check("t3_read_first_ops", 128'({cmd_op_q[c0], cmd_op_q[c0+3]}), 128'h9);
    check("t3_no_write_during_rd", 128'(wren_cnt - w0), 128'd0);
    check("t3_awready_at_last", 128'(aw_at_last), 128'd1);
    write_burst(32'h6000, 3, 3, 1'b0, 1'b1);
    check("t3_wr_addr", 128'(cmd_addr_q[c0 + 4]), 128'hC00);
    check("t3_wr_op", 128'(cmd_op_q[c0 + 4]), 128'd0);
    bresp(0);

    // ---- T4: wlast on wrong beat ----
    w0 = wren_cnt;
    write_burst(32'h7000, 3, 2, 1'b0, 1'b0);
    check("t4_wren_count", 128'(wren_cnt - w0), 128'd4);
    check("t4_wlast_err", 128'(wlast_err_o), 128'd1);
    bresp(1);
    check("t4_wlast_err_sticky", 128'(wlast_err_o), 128'd1);

    // ---- T5: reset on read beat 2 of 8 ----
    issue_read(32'h3000, 7, 1'b0, 32'h0, 1'b0);
    repeat (5) @(posedge clk_i);
    #1;
    for (int k = 0; k < 2; k++) begin
      app_rd_data_i = beat_pat(40 + k); app_rd_data_valid_i = 1'b1;
      @(posedge clk_i); #1;
    end
    app_rd_data_i = beat_pat(42); reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0; app_rd_data_i = beat_pat(43);
    @(negedge clk_i);
    check("t5_arready", 128'(arready_o), 128'd1);
    check("t5_app_en", 128'(app_en_o), 128'd0);
    check("t5_data_valid", 128'(data_valid_o), 128'd0);
    check("t5_data", data_o[127:0], 128'd0);
    check("t5_wlast_err_cleared", 128'(wlast_err_o), 128'd0);
    check("t5_bvalid", 128'(bvalid_o), 128'd0);
    #1 r0 = rd_q.size();
    for (int k = 4; k < 8; k++) begin
      @(posedge clk_i); #1;
      app_rd_data_i = beat_pat(40 + k);
    end
    @(posedge clk_i); #1;
    app_rd_data_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 check("t5_stray_dropped", 128'(rd_q.size() - r0), 128'd0);

    // ---- T6: 20-cycle app_rdy stall during a read ----
    c0 = cmd_addr_q.size(); r0 = rd_q.size();
    issue_read(32'h4000, 3, 1'b0, 32'h0, 1'b1);
    return_beats(4, 60);
    check("t6_cmd_count", 128'(cmd_addr_q.size() - c0), 128'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t6_cmd_addr%0d", i), 128'(cmd_addr_q[c0 + i]), 128'(28'h800 + 28'(16 * i)));
    check("t6_beats", 128'(rd_q.size() - r0), 128'd4);
    check("t6_last", 128'(last_q[r0 + 3]), 128'd1);
    check("t6_data3", rd_q[r0 + 3], exp128(63));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_accel_mig_responder
